// File: rtl/led_frame_scheduler_pkg.sv
// Shared definitions for the LED frame scheduler: FSM encoding, framing words
// and the snake-wiring pixel map also used by the scroll engine.
package led_frame_scheduler_pkg;

  localparam logic [31:0] START_WORD = 32'h0000_0000;
  localparam logic [31:0] END_WORD   = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_START,
    ST_PIX,
    ST_END,
    ST_GAP
  } state_t;

  // Physical pixel p -> display bit index; even rows are wired right-to-left.
  function automatic int snake_map(input int p, input int row_w);
    int row;
    int col;
    row = p / row_w;
    col = p % row_w;
    if (row[0] == 1'b0) begin
      return row * row_w + row_w - 1 - col;
    end
    return p;
  endfunction

endpackage

// File: rtl/led_frame_scheduler_if.sv
// Word stream from the frame scheduler to the downstream word serializer.
interface led_frame_scheduler_if;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/led_frame_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from the current requests, pointer
// moves to the other source whenever a grant is committed.
module led_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       win_idx,
  output logic [1:0] gnt
);
  logic ptr_reg;
  logic pick;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= 1'b0;
    end else if (update) begin
      ptr_reg <= ~win_idx;
    end
  end

  // Only a contested request consults the pointer.
  assign pick = (req == 2'b11) ? ptr_reg : req[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_gnt
      assign gnt[gi] = req[gi] && (pick == 1'(gi));
    end
  endgenerate
endmodule

// File: rtl/led_frame_scheduler.sv
// Frame sequencer for the 8x8 LED matrix: arbitrates two frame sources, latches
// the winner's image and streams start word, pixel words and end words.
module led_frame_scheduler
  import led_frame_scheduler_pkg::*;
#(
  parameter int NUM_PIX   = 64,
  parameter int ROW_W     = 8,
  parameter int END_WORDS = 2,
  parameter int FRAME_GAP = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               req,
  input  logic [NUM_PIX-1:0]       src0_bitmap,
  input  logic [31:0]              src0_fg,
  input  logic [31:0]              src0_bg,
  input  logic [NUM_PIX-1:0]       src1_bitmap,
  input  logic [31:0]              src1_fg,
  input  logic [31:0]              src1_bg,
  output logic [1:0]               grant,
  led_frame_scheduler_if.master    word_if,
  output logic                     busy,
  output logic                     frame_done
);
  localparam int PIX_W = $clog2(NUM_PIX);
  localparam int END_W = $clog2(END_WORDS + 1);
  localparam int GAP_W = $clog2(FRAME_GAP + 1);

  state_t             state_reg, state_next;
  logic [1:0]         sel_reg;
  logic [1:0]         arb_gnt;
  logic [NUM_PIX-1:0] bitmap_reg;
  logic [31:0]        fg_reg, bg_reg;
  logic [PIX_W-1:0]   pix_reg;
  logic [END_W-1:0]   end_reg;
  logic [GAP_W-1:0]   gap_reg;
  logic [PIX_W-1:0]   map_idx, bit_pos;
  logic               xfer;

  led_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .update  (state_reg == ST_LATCH),
    .win_idx (sel_reg[1]),
    .gnt     (arb_gnt)
  );

  assign xfer    = word_if.word_valid && word_if.word_ready;
  assign map_idx = PIX_W'(snake_map(int'(pix_reg), ROW_W));
  // Display bit i lives at bitmap[NUM_PIX-1-i].
  assign bit_pos = PIX_W'(NUM_PIX - 1) - map_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (req != 2'b00) state_next = ST_LATCH;
      ST_LATCH: state_next = ST_START;
      ST_START: if (xfer) state_next = ST_PIX;
      ST_PIX:   if (xfer && pix_reg == PIX_W'(NUM_PIX - 1)) state_next = ST_END;
      ST_END:   if (xfer && end_reg == END_W'(END_WORDS - 1)) state_next = ST_GAP;
      ST_GAP:   if (gap_reg == GAP_W'(FRAME_GAP - 1)) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Source data is captured once per frame so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_reg    <= 2'b00;
      bitmap_reg <= '0;
      fg_reg     <= '0;
      bg_reg     <= '0;
      pix_reg    <= '0;
      end_reg    <= '0;
      gap_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: sel_reg <= arb_gnt;
        ST_LATCH: begin
          bitmap_reg <= sel_reg[1] ? src1_bitmap : src0_bitmap;
          fg_reg     <= sel_reg[1] ? src1_fg     : src0_fg;
          bg_reg     <= sel_reg[1] ? src1_bg     : src0_bg;
          pix_reg    <= '0;
          end_reg    <= '0;
          gap_reg    <= '0;
        end
        ST_PIX:  if (xfer) pix_reg <= pix_reg + 1'b1;
        ST_END:  if (xfer) end_reg <= end_reg + 1'b1;
        ST_GAP:  gap_reg <= gap_reg + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    grant              = 2'b00;
    busy               = 1'b0;
    frame_done         = 1'b0;
    word_if.word_valid = 1'b0;
    word_if.word_data  = 32'h0;
    case (state_reg)
      ST_LATCH: begin
        grant = sel_reg;
        busy  = 1'b1;
      end
      ST_START: begin
        busy               = 1'b1;
        word_if.word_valid = 1'b1;
        word_if.word_data  = START_WORD;
      end
      ST_PIX: begin
        busy               = 1'b1;
        word_if.word_valid = 1'b1;
        word_if.word_data  = bitmap_reg[bit_pos] ? fg_reg : bg_reg;
      end
      ST_END: begin
        busy               = 1'b1;
        word_if.word_valid = 1'b1;
        word_if.word_data  = END_WORD;
      end
      ST_GAP:  frame_done = (gap_reg == '0);
      default: ;
    endcase
  end
endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed and randomized frames checked against an image-level model of the
// matrix refresh stream, arbitration order and frame spacing.
module tb_led_frame_scheduler;
  localparam int NUM_PIX   = 64;
  localparam int ROW_W     = 8;
  localparam int END_WORDS = 2;
  localparam int FRAME_GAP = 1000;
  localparam int FRAME_LEN = 1 + NUM_PIX + END_WORDS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [63:0] src0_bitmap = '0, src1_bitmap = '0;
  logic [31:0] src0_fg = '0, src0_bg = '0, src1_fg = '0, src1_bg = '0;
  logic [1:0]  grant;
  logic        busy, frame_done;

  led_frame_scheduler_if wif ();

  led_frame_scheduler #(
    .NUM_PIX(NUM_PIX), .ROW_W(ROW_W), .END_WORDS(END_WORDS), .FRAME_GAP(FRAME_GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .src0_bitmap (src0_bitmap),
    .src0_fg     (src0_fg),
    .src0_bg     (src0_bg),
    .src1_bitmap (src1_bitmap),
    .src1_fg     (src1_fg),
    .src1_bg     (src1_bg),
    .grant       (grant),
    .word_if     (wif),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  initial forever #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          rand_stall = 1'b0;
  logic        model_ptr = 1'b0;
  logic [31:0] cap[$];
  logic [31:0] exp_q[$];
  logic [1:0]  grants[$];
  int          grant_cyc[$];
  int          done_cyc[$];
  int          vrise_cyc[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Matrix image, scanned along the snake: even rows right-to-left.
  task automatic push_frame(input logic [63:0] bm, input logic [31:0] fg, input logic [31:0] bg);
    logic img [ROW_W][ROW_W];
    for (int r = 0; r < ROW_W; r++)
      for (int c = 0; c < ROW_W; c++)
        img[r][c] = bm[NUM_PIX - 1 - (r * ROW_W + c)];
    exp_q.push_back(32'h0);
    for (int r = 0; r < ROW_W; r++)
      for (int k = 0; k < ROW_W; k++)
        exp_q.push_back(img[r][(r % 2 == 0) ? (ROW_W - 1 - k) : k] ? fg : bg);
    for (int e = 0; e < END_WORDS; e++) exp_q.push_back(32'h0);
  endtask

  function automatic logic [1:0] model_pick(input logic [1:0] r);
    if (r == 2'b11) return model_ptr ? 2'b10 : 2'b01;
    return r;
  endfunction

  // Ready driver: stalls randomly when enabled.
  initial begin
    wif.word_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      wif.word_ready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: records transfers, grants, frame ends; checks data holds under stall.
  initial begin
    bit          hold_pending;
    logic [31:0] hold_data;
    logic        valid_prev;
    hold_pending = 1'b0;
    hold_data    = '0;
    valid_prev   = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        hold_pending = 1'b0;
        valid_prev   = 1'b0;
      end else begin
        if (hold_pending) begin
          check("hold_valid", wif.word_valid, 1'b1);
          check("hold_data", wif.word_data, hold_data);
        end
        hold_pending = wif.word_valid && !wif.word_ready;
        hold_data    = wif.word_data;
        if (wif.word_valid && wif.word_ready) cap.push_back(wif.word_data);
        if (wif.word_valid && !valid_prev) vrise_cyc.push_back(cyc);
        valid_prev = wif.word_valid;
        if (grant != 2'b00) begin
          grants.push_back(grant);
          grant_cyc.push_back(cyc);
          check("busy_at_grant", busy, 1'b1);
        end
        if (frame_done) done_cyc.push_back(cyc);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    check("rst_grant", grant, 2'b00);
    check("rst_valid", wif.word_valid, 1'b0);
    check("rst_data", wif.word_data, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    reset = 1'b0;
    model_ptr = 1'b0;
  endtask

  task automatic do_frame(input logic [1:0] r, input int nframes, input int mutate_at,
                          input int abort_at, input string tag);
    int   budget, snaps, bad;
    logic [1:0] w;
    bit   aborted;
    cap.delete(); exp_q.delete(); grants.delete();
    grant_cyc.delete(); done_cyc.delete(); vrise_cyc.delete();
    budget = 0; snaps = 0; aborted = 1'b0;
    req = r;
    while (done_cyc.size() < nframes && budget < 2600 * nframes) begin
      tick();
      budget++;
      if (grants.size() > snaps) begin
        w = model_pick(r);
        check($sformatf("%s_grant%0d", tag, snaps), grants[snaps], w);
        if (w[1]) push_frame(src1_bitmap, src1_fg, src1_bg);
        else      push_frame(src0_bitmap, src0_fg, src0_bg);
        model_ptr = w[0];
        snaps++;
      end
      if (mutate_at >= 0 && cap.size() >= mutate_at) begin
        src0_bitmap = '1;
        src0_fg     = 32'h00AB_CDEF;
      end
      if (abort_at >= 0 && cap.size() == abort_at) begin
        reset = 1'b1;
        tick();
        check({tag, "_valid"}, wif.word_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        reset = 1'b0;
        model_ptr = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    req = 2'b00;
    if (!aborted) begin
      check({tag, "_frames"}, done_cyc.size(), nframes);
      check({tag, "_ngrants"}, grants.size(), nframes);
      check({tag, "_count"}, cap.size(), FRAME_LEN * nframes);
      bad = -1;
      for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
        if (cap[i] !== exp_q[i] && bad < 0) bad = i;
      if (bad < 0) bad = 0;
      check($sformatf("%s_word%0d", tag, bad), cap[bad], exp_q[bad]);
      for (int k = 0; k < nframes; k++) begin
        check($sformatf("%s_lat%0d", tag, k), vrise_cyc[k] - grant_cyc[k], 1);
        if (k > 0)  // GAP cycles, then one IDLE sampling cycle, then the grant
          check($sformatf("%s_gap%0d", tag, k), grant_cyc[k] - done_cyc[k-1], FRAME_GAP + 1);
      end
    end
    $display("frame %-10s req=%b grants=%0d words=%0d aborted=%0d", tag, r, grants.size(),
             cap.size(), aborted);
  endtask

  initial begin
    logic [1:0] r;
    do_reset();

    src0_bitmap = 64'h8000_0000_0000_0000; src0_fg = 32'hFF00_00FF; src0_bg = 32'hFF00_0000;
    src1_bitmap = 64'h0F0F_0F0F_F0F0_F0F0; src1_fg = 32'hE100_FF00; src1_bg = 32'hE000_0010;
    do_frame(2'b01, 1, -1, -1, "single");

    src0_bitmap = 64'h00FF_0000_0000_0000;
    do_frame(2'b01, 1, -1, -1, "odd_row");

    src0_bitmap = 64'h8000_0000_0000_0000;
    rand_stall = 1'b1;
    do_frame(2'b01, 1, -1, -1, "stall");
    rand_stall = 1'b0;

    do_frame(2'b01, 1, 20, -1, "mutate");

    src0_bitmap = 64'h8000_0000_0000_0000; src0_fg = 32'hFF00_00FF;
    do_frame(2'b01, 1, -1, 31, "abort");
    do_frame(2'b01, 1, -1, -1, "post_rst");

    do_reset();
    src1_bitmap = 64'h0123_4567_89AB_CDEF; src1_fg = 32'hE0FF_00FF; src1_bg = 32'hE000_FF00;
    do_frame(2'b11, 3, -1, -1, "rr");

    for (int n = 0; n < 4; n++) begin
      src0_bitmap = {$urandom, $urandom}; src0_fg = $urandom; src0_bg = $urandom;
      src1_bitmap = {$urandom, $urandom}; src1_fg = $urandom; src1_bg = $urandom;
      r = 2'($urandom_range(1, 3));
      rand_stall = n[0];
      do_frame(r, 1, -1, -1, $sformatf("rand%0d", n));
    end
    rand_stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
